// File: rtl/video_stream_checker.sv
// Video stream framing checker: SOF/EOL protocol errors, frame counting, done.
// Define FRAME_CHECKSUM_EN to build the per-channel frame checksum accumulators.
module video_stream_checker #(
    parameter int N_x        = 640,
    parameter int N_y        = 480,
    parameter int CH         = 3,
    parameter int CW         = 8,
    parameter int N_FRAMES   = 1,
    parameter int DONE_DELAY = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    input  logic [CH*CW-1:0] s_axis_tdata,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic [3:0]       err_flags,
    output logic [CH*32-1:0] checksum,
    output logic             done
);

    localparam int XW = (N_x > 1) ? $clog2(N_x) : 1;
    localparam int YW = (N_y > 1) ? $clog2(N_y) : 1;
    localparam int DW = (DONE_DELAY > 1) ? $clog2(DONE_DELAY) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(N_x - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(N_y - 1);
    localparam logic [DW-1:0] D_LAST =
        DW'((DONE_DELAY > 0) ? DONE_DELAY - 1 : 0);
    localparam logic [15:0] F_LAST = 16'(N_FRAMES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] dcnt;

    logic          counted;
    logic          restart;
    logic          at_origin;
    logic          sof_early;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          line_end;
    logic          frame_end;
    logic          eol_early;
    logic          eol_miss;
    logic [15:0]   fc_inc;

    // A tuser pixel always becomes (0,0); px/py is the position it really takes.
    always_comb begin
        counted   = s_axis_tvalid &&
                    (state == ACTIVE || (state == IDLE && s_axis_tuser));
        restart   = counted && s_axis_tuser;
        at_origin = (x == '0) && (y == '0);
        sof_early = restart && (state == ACTIVE) && !at_origin;
        px        = restart ? '0 : x;
        py        = restart ? '0 : y;
        line_end  = s_axis_tlast || (px == X_LAST);
        frame_end = counted && line_end && (py == Y_LAST) && !sof_early;
        eol_early = counted && s_axis_tlast && (px != X_LAST);
        eol_miss  = counted && !s_axis_tlast && (px == X_LAST);
        fc_inc    = frame_count + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            dcnt        <= '0;
            frame_count <= '0;
            err_flags   <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s_axis_tvalid && !s_axis_tuser)
                        err_flags[0] <= 1'b1;
                end
                DRAIN: begin
                    if (s_axis_tvalid) begin
                        dcnt         <= '0;
                        err_flags[0] <= 1'b1;
                    end else if (dcnt == D_LAST) begin
                        state <= DONE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                ACTIVE: ;
                DONE: ;
            endcase
            if (counted) begin
                if (sof_early) err_flags[1] <= 1'b1;
                if (eol_early) err_flags[2] <= 1'b1;
                if (eol_miss)  err_flags[3] <= 1'b1;
                if (frame_end) begin
                    x           <= '0;
                    y           <= '0;
                    dcnt        <= '0;
                    frame_done  <= 1'b1;
                    frame_count <= fc_inc;
                    state       <= (fc_inc == F_LAST) ? DRAIN : IDLE;
                end else if (line_end) begin
                    x     <= '0;
                    y     <= py + YW'(1);
                    state <= ACTIVE;
                end else begin
                    x     <= px + XW'(1);
                    y     <= py;
                    state <= ACTIVE;
                end
            end
        end
    end

    assign done = (state == DONE);

`ifdef FRAME_CHECKSUM_EN
    logic [CH*32-1:0] acc_q;
    logic [CH*32-1:0] acc_n;
    logic [CH*32-1:0] sum_q;

    always_comb begin
        acc_n = restart ? '0 : acc_q;
        for (int i = 0; i < CH; i++)
            acc_n[i*32 +: 32] = acc_n[i*32 +: 32]
                              + 32'(s_axis_tdata[i*CW +: CW]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else if (counted) begin
            if (frame_end) begin
                sum_q <= acc_n;
                acc_q <= '0;
            end else begin
                acc_q <= acc_n;
            end
        end
    end

    assign checksum = sum_q;
`else
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata;
    assign checksum     = '0;
`endif

endmodule

// File: tb/tb_video_stream_checker.sv
// Directed scoreboard bench for video_stream_checker on an 8x4 frame.
// Expected checksums follow FRAME_CHECKSUM_EN as seen by this compile.
module tb_video_stream_checker;

    localparam int NX = 8;
    localparam int NY = 4;
    localparam int CH = 3;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tvalid = 1'b0;
    logic             tuser = 1'b0;
    logic             tlast = 1'b0;
    logic [CH*CW-1:0] tdata = '0;
    logic             frame_done;
    logic [15:0]      frame_count;
    logic [3:0]       err_flags;
    logic [CH*32-1:0] checksum;
    logic             done;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_frames;
    logic [31:0] sum [CH];
    logic [15:0] exp_cnt_q [$];
    logic [95:0] exp_chk_q [$];

    video_stream_checker #(
        .N_x(NX), .N_y(NY), .CH(CH), .CW(CW),
        .N_FRAMES(2), .DONE_DELAY(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tvalid(tvalid),
        .s_axis_tuser(tuser),
        .s_axis_tlast(tlast),
        .s_axis_tdata(tdata),
        .frame_done(frame_done),
        .frame_count(frame_count),
        .err_flags(err_flags),
        .checksum(checksum),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [95:0] obs,
                         input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Scoreboard consumer: every frame_done must match a queued frame end.
    always @(negedge clk) begin
        if (frame_done) begin
            check("frame_done_expected", 96'(exp_cnt_q.size() != 0), 96'd1);
            if (exp_cnt_q.size() != 0) begin
                check("frame_count_at_done", 96'(frame_count),
                      96'(exp_cnt_q.pop_front()));
                check("checksum_at_done", checksum, exp_chk_q.pop_front());
            end
        end
    end

    task automatic clear_model();
        exp_frames = '0;
        for (int i = 0; i < CH; i++) sum[i] = '0;
        exp_cnt_q.delete();
        exp_chk_q.delete();
    endtask

    task automatic do_reset(input bit junk);
        @(negedge clk);
        rst = 1'b1;
        tvalid = junk;
        tuser = junk;
        tlast = junk;
        tdata = '1;
        @(negedge clk);
        rst = 1'b0;
        tvalid = 1'b0;
        tuser = 1'b0;
        tlast = 1'b0;
        clear_model();
    endtask

    task automatic gap();
        @(negedge clk);
        tvalid = 1'b0;
        tuser = 1'b0;
        tlast = 1'b0;
    endtask

    task automatic send(input logic u, input logic l,
                        input logic [CH*CW-1:0] d, input bit fe);
        @(negedge clk);
        tvalid = 1'b1;
        tuser = u;
        tlast = l;
        tdata = d;
        if (u)
            for (int i = 0; i < CH; i++) sum[i] = '0;
        for (int i = 0; i < CH; i++)
            sum[i] += 32'(d[i*CW +: CW]);
        if (fe) begin
            exp_frames++;
            exp_cnt_q.push_back(exp_frames);
`ifdef FRAME_CHECKSUM_EN
            exp_chk_q.push_back({sum[2], sum[1], sum[0]});
`else
            exp_chk_q.push_back(96'd0);
`endif
            for (int i = 0; i < CH; i++) sum[i] = '0;
        end
    endtask

    task automatic clean_frame(input bit vary, input bit gaps);
        logic [CH*CW-1:0] d;
        bit last;
        for (int y = 0; y < NY; y++)
            for (int x = 0; x < NX; x++) begin
                d = vary ? {8'(x * 3 + y + 1), 8'(y * 17 + 5), 8'(x + y * 8)}
                         : 24'h010203;
                last = (x == NX - 1) && (y == NY - 1);
                send(x == 0 && y == 0, x == NX - 1, d, last);
                if (gaps && !last) gap();
            end
    endtask

    task automatic wait_done(output int n);
        @(negedge clk);
        tvalid = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_frame_done"}, 96'(frame_done), 96'd0);
        check({tag, "_frame_count"}, 96'(frame_count), 96'd0);
        check({tag, "_err_flags"}, 96'(err_flags), 96'd0);
        check({tag, "_checksum"}, checksum, 96'd0);
        check({tag, "_done"}, 96'(done), 96'd0);
    endtask

    task automatic settle_check(input string tag, input logic [3:0] err,
                                input logic [15:0] fc);
        repeat (2) gap();
        check({tag, "_err_flags"}, 96'(err_flags), 96'(err));
        check({tag, "_frame_count"}, 96'(frame_count), 96'(fc));
        check({tag, "_pending"}, 96'(exp_cnt_q.size()), 96'd0);
    endtask

    int n;

    initial begin
        clear_model();

        // Two clean frames with idle gaps, then drain into done.
        do_reset(1'b0);
        check_zero("reset");
        clean_frame(1'b0, 1'b1);
        gap();
        clean_frame(1'b0, 1'b1);
        wait_done(n);
        check("a_done_latency", 96'(n), 96'd64);
        check("a_err_flags", 96'(err_flags), 96'd0);
        check("a_frame_count", 96'(frame_count), 96'd2);
`ifdef FRAME_CHECKSUM_EN
        check("a_checksum", checksum, 96'h00000020_00000040_00000060);
`else
        check("a_checksum", checksum, 96'd0);
`endif
        check("a_pending", 96'(exp_cnt_q.size()), 96'd0);
        send(1'b1, 1'b1, 24'h0, 1'b0);
        gap();
        check("a_done_hold", 96'(done), 96'd1);
        check("a_done_ignore", 96'(err_flags), 96'd0);

        // Stray pixels before SOF.
        do_reset(1'b0);
        repeat (3) send(1'b0, 1'b0, 24'h112233, 1'b0);
        clean_frame(1'b1, 1'b0);
        settle_check("b", 4'b0001, 16'd1);

        // Early tlast at x=5 on line 1: 30-pixel frame.
        do_reset(1'b0);
        for (int y = 0; y < NY; y++) begin
            int xm;
            xm = (y == 1) ? 5 : NX - 1;
            for (int x = 0; x <= xm; x++)
                send(x == 0 && y == 0, x == xm, {8'(x), 8'(y), 8'(x ^ y)},
                     x == xm && y == NY - 1);
        end
        settle_check("c", 4'b0100, 16'd1);

        // SOF at pixel 10, then SOF on a frame-ending pixel.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++)
            send(i == 0, (i % NX) == NX - 1, 24'h0a0b0c, 1'b0);
        clean_frame(1'b1, 1'b0);
        settle_check("d1", 4'b0010, 16'd1);
        for (int i = 0; i < NX * NY - 1; i++)
            send(i == 0, (i % NX) == NX - 1, 24'h050607, 1'b0);
        clean_frame(1'b1, 1'b0);
        settle_check("d2", 4'b0010, 16'd2);

        // Reset mid-frame, with a pixel presented during reset.
        do_reset(1'b0);
        for (int i = 0; i <= 20; i++)
            send(i == 0, (i % NX) == NX - 1, 24'h334455, 1'b0);
        do_reset(1'b1);
        check_zero("e_rst");
        clean_frame(1'b1, 1'b0);
        settle_check("e", 4'b0000, 16'd1);

        // Pixel arriving during drain restarts the done delay.
        do_reset(1'b0);
        clean_frame(1'b1, 1'b0);
        clean_frame(1'b0, 1'b0);
        repeat (30) gap();
        check("f_not_done", 96'(done), 96'd0);
        send(1'b0, 1'b0, 24'h777777, 1'b0);
        wait_done(n);
        check("f_done_latency", 96'(n), 96'd64);
        check("f_err_flags", 96'(err_flags), 96'd1);
        check("f_frame_count", 96'(frame_count), 96'd2);
        check("f_pending", 96'(exp_cnt_q.size()), 96'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
